// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU pixel compositor.
// Sprite attribute bundle, dot/line limits and a bit-reverse helper.
package ppu_pkg;

  typedef struct packed {
    logic       hflip;
    logic       behind;
    logic [1:0] pal;
  } spr_attr_t;

  localparam int VIS_DOTS       = 256;
  localparam int SPR_LOAD_FIRST = 257;
  localparam int SPR_LOAD_LAST  = 320;
  localparam int VIS_LINES      = 240;
  localparam int PRE_LINE       = 261;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ppu_pixel_compositor_if.sv
// Render-path bundle between the fetchers, the compositor and palette RAM.
// master drives dot/load inputs; slave is the compositor.
interface ppu_pixel_compositor_if #(
  parameter int NUM_SPR = 8,
  parameter int SLOT_W  = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
);
  logic [9:0]        x_idx;
  logic [9:0]        scanline;
  logic [3:0]        bg_pixel;
  logic              show_bg;
  logic              show_spr;
  logic              show_bg_left;
  logic              show_spr_left;
  logic              load_en;
  logic [SLOT_W-1:0] load_slot;
  logic [7:0]        load_x;
  logic [7:0]        load_attr;
  logic [7:0]        load_pt_lo;
  logic [7:0]        load_pt_hi;
  logic              load_is_spr0;
  logic [4:0]        pixel;
  logic              pixel_valid;
  logic              spr0_hit;

  modport master (
    output x_idx, scanline, bg_pixel,
    output show_bg, show_spr, show_bg_left, show_spr_left,
    output load_en, load_slot, load_x, load_attr,
    output load_pt_lo, load_pt_hi, load_is_spr0,
    input  pixel, pixel_valid, spr0_hit
  );

  modport slave (
    input  x_idx, scanline, bg_pixel,
    input  show_bg, show_spr, show_bg_left, show_spr_left,
    input  load_en, load_slot, load_x, load_attr,
    input  load_pt_lo, load_pt_hi, load_is_spr0,
    output pixel, pixel_valid, spr0_hit
  );
endinterface

// File: rtl/ppu_spr_slot.sv
// One sprite output slot: X delay counter plus pattern shifters.
// is_spr0 storage exists only when PPU_SPR0_HIT_EN is defined.
module ppu_spr_slot
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] x_i,
  input  spr_attr_t  attr_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] hi_i,
`ifdef PPU_SPR0_HIT_EN
  input  logic       spr0_i,
  output logic       spr0_o,
`endif
  output logic [1:0] col_o,
  output logic [1:0] pal_o,
  output logic       behind_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic [1:0] pal_q, pal_d;
  logic       beh_q, beh_d;
`ifdef PPU_SPR0_HIT_EN
  logic       s0_q, s0_d;
`endif

  // Clear at end of visible dots, load in window, count/shift on visible dots
  always_comb begin
    cnt_d = cnt_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    pal_d = pal_q;
    beh_d = beh_q;
`ifdef PPU_SPR0_HIT_EN
    s0_d  = s0_q;
`endif
    if (clr_i) begin
      cnt_d = 8'd0;
      lo_d  = 8'd0;
      hi_d  = 8'd0;
      pal_d = 2'd0;
      beh_d = 1'b0;
`ifdef PPU_SPR0_HIT_EN
      s0_d  = 1'b0;
`endif
    end else if (load_i) begin
      cnt_d = x_i;
      lo_d  = attr_i.hflip ? rev8(lo_i) : lo_i;
      hi_d  = attr_i.hflip ? rev8(hi_i) : hi_i;
      pal_d = attr_i.pal;
      beh_d = attr_i.behind;
`ifdef PPU_SPR0_HIT_EN
      s0_d  = spr0_i;
`endif
    end else if (shift_i) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        lo_d = {lo_q[6:0], 1'b0};
        hi_d = {hi_q[6:0], 1'b0};
      end
    end
  end

  // Slot state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
      lo_q  <= 8'd0;
      hi_q  <= 8'd0;
      pal_q <= 2'd0;
      beh_q <= 1'b0;
`ifdef PPU_SPR0_HIT_EN
      s0_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      pal_q <= pal_d;
      beh_q <= beh_d;
`ifdef PPU_SPR0_HIT_EN
      s0_q  <= s0_d;
`endif
    end
  end

  assign col_o    = (cnt_q == 8'd0) ? {hi_q[7], lo_q[7]} : 2'b00;
  assign pal_o    = pal_q;
  assign behind_o = beh_q;
`ifdef PPU_SPR0_HIT_EN
  assign spr0_o   = s0_q;
`endif

endmodule

// File: rtl/ppu_pixel_compositor.sv
// Per-dot sprite/background compositor with registered palette address.
// Define PPU_SPR0_HIT_EN to build the sticky sprite-0 hit flag.
module ppu_pixel_compositor
  import ppu_pkg::*;
#(
  parameter int NUM_SPR = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ppu_pixel_compositor_if.slave  bus
);

  localparam int SLOT_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  logic       vis;
  logic       left;
  logic       clr;
  logic       win;
  logic       bg_on;
  logic       spr_on;
  logic [1:0] bg_col;
  logic [3:0] bg_eff;
  logic [1:0] sp_col;
  logic [1:0] w_col;
  logic [1:0] w_pal;
  logic       w_beh;
  logic [4:0] pix_q, pix_d;
  logic       val_q, val_d;
  spr_attr_t  ld_attr;
  logic [3:0] unused_attr;

  logic [1:0] col [NUM_SPR];
  logic [1:0] pal [NUM_SPR];
  logic       beh [NUM_SPR];

  assign vis = (bus.scanline < 10'(VIS_LINES))
            && (bus.x_idx < 10'(VIS_DOTS));
  assign left = bus.x_idx < 10'd8;
  assign clr = bus.x_idx == 10'(VIS_DOTS);
  assign win = (bus.x_idx >= 10'(SPR_LOAD_FIRST))
            && (bus.x_idx <= 10'(SPR_LOAD_LAST));

  assign ld_attr.hflip  = bus.load_attr[6];
  assign ld_attr.behind = bus.load_attr[5];
  assign ld_attr.pal    = bus.load_attr[1:0];
  assign unused_attr = {bus.load_attr[7], bus.load_attr[4:2]};

`ifdef PPU_SPR0_HIT_EN
  logic [NUM_SPR-1:0] s0;
`endif

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_slot
    ppu_spr_slot u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (clr),
      .load_i   (win && bus.load_en
                 && (bus.load_slot == SLOT_W'(g))),
      .shift_i  (vis),
      .x_i      (bus.load_x),
      .attr_i   (ld_attr),
      .lo_i     (bus.load_pt_lo),
      .hi_i     (bus.load_pt_hi),
`ifdef PPU_SPR0_HIT_EN
      .spr0_i   (bus.load_is_spr0),
      .spr0_o   (s0[g]),
`endif
      .col_o    (col[g]),
      .pal_o    (pal[g]),
      .behind_o (beh[g])
    );
  end

  // Lowest-index opaque slot wins
  always_comb begin
    w_col = 2'd0;
    w_pal = 2'd0;
    w_beh = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (col[i] != 2'd0) begin
        w_col = col[i];
        w_pal = pal[i];
        w_beh = beh[i];
      end
    end
  end

  assign bg_on  = bus.show_bg && (!left || bus.show_bg_left);
  assign spr_on = bus.show_spr && (!left || bus.show_spr_left);
  assign bg_col = bg_on ? bus.bg_pixel[1:0] : 2'd0;
  assign bg_eff = (bg_col == 2'd0) ? 4'h0 : bus.bg_pixel;
  assign sp_col = spr_on ? w_col : 2'd0;

  // Compose and hold the last pixel outside visible dots
  always_comb begin
    pix_d = pix_q;
    val_d = 1'b0;
    if (vis) begin
      val_d = 1'b1;
      if (sp_col == 2'd0)
        pix_d = {1'b0, bg_eff};
      else if ((bg_col != 2'd0) && w_beh)
        pix_d = {1'b0, bg_eff};
      else
        pix_d = {1'b1, w_pal, sp_col};
    end
  end

  // Output pixel register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= 5'h00;
      val_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      val_q <= val_d;
    end
  end

  assign bus.pixel       = pix_q;
  assign bus.pixel_valid = val_q;

`ifdef PPU_SPR0_HIT_EN
  logic hit_q, hit_d;
  logic s0_any;
  logic hit_set;
  logic hit_clr;

  // Any sprite-0 slot opaque on this dot
  always_comb begin
    s0_any = 1'b0;
    for (int i = 0; i < NUM_SPR; i++)
      if (s0[i] && (col[i] != 2'd0)) s0_any = 1'b1;
  end

  assign hit_set = vis && bus.show_bg && bus.show_spr
                && spr_on && s0_any && (bg_col != 2'd0)
                && (bus.x_idx != 10'(VIS_DOTS - 1));
  assign hit_clr = (bus.scanline == 10'(PRE_LINE))
                && (bus.x_idx == 10'd1);

  // Sticky hit; pre-render clear has priority
  always_comb begin
    hit_d = hit_q;
    if (hit_clr) hit_d = 1'b0;
    else if (hit_set) hit_d = 1'b1;
  end

  // Hit flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hit_q <= 1'b0;
    else hit_q <= hit_d;
  end

  assign bus.spr0_hit = hit_q;
`else
  logic unused_spr0;
  assign unused_spr0 = bus.load_is_spr0;
  assign bus.spr0_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ppu_pixel_compositor.sv
// Bench for ppu_pixel_compositor: directed lines plus random lines.
// Reference model places sprites geometrically from their X position.
module tb_ppu_pixel_compositor;

  localparam int NS = 8;
  localparam int SW = 3;
`ifdef PPU_SPR0_HIT_EN
  localparam logic HIT = 1'b1;
`else
  localparam logic HIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ppu_pixel_compositor_if #(.NUM_SPR(NS)) bus ();

  ppu_pixel_compositor #(.NUM_SPR(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference slot contents
  int         m_x  [NS];
  logic [7:0] m_lo [NS];
  logic [7:0] m_hi [NS];
  logic       m_hf [NS];
  logic       m_bh [NS];
  logic       m_s0 [NS];
  logic [1:0] m_pl [NS];
  logic [4:0] e_pix;
  logic       e_val;
  logic       e_hit;

  // per-line schedule
  logic       s_en   [341];
  int         s_slot [341];
  int         s_x    [341];
  logic [7:0] s_attr [341];
  logic [7:0] s_lo   [341];
  logic [7:0] s_hi   [341];
  logic       s_s0   [341];
  logic [3:0] bg_line[341];
  logic [4:0] cap_pix[256];
  logic       cap_hit[256];
  int         rst_at = -1;
  logic       l_sbg, l_sspr, l_sbgl, l_ssprl;

  function automatic logic [1:0] slot_col(int i, int x);
    int d, b;
    d = x - m_x[i];
    if (d < 0 || d > 7) return 2'b00;
    b = m_hf[i] ? d : 7 - d;
    return {m_hi[i][b], m_lo[i][b]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_lo[i] = 0; m_hi[i] = 0;
      m_hf[i] = 0; m_bh[i] = 0; m_s0[i] = 0; m_pl[i] = 0;
    end
  endtask

  task automatic model_step();
    int x, sl, w;
    logic vis, bon, son, s0a, set;
    logic [1:0] bgc, spc;
    logic [3:0] bge;
    if (!reset_n) begin
      model_clear();
      e_pix = 0; e_val = 0; e_hit = 0;
      return;
    end
    x = int'(bus.x_idx);
    sl = int'(bus.scanline);
    vis = (sl < 240) && (x < 256);
    bon = bus.show_bg && (x >= 8 || bus.show_bg_left);
    son = bus.show_spr && (x >= 8 || bus.show_spr_left);
    bgc = bon ? bus.bg_pixel[1:0] : 2'b00;
    bge = (bgc == 0) ? 4'h0 : bus.bg_pixel;
    w = -1;
    s0a = 0;
    for (int i = 0; i < NS; i++) begin
      if (slot_col(i, x) != 0 && w < 0) w = i;
      if (m_s0[i] && slot_col(i, x) != 0 && son) s0a = 1;
    end
    spc = (son && w >= 0) ? slot_col(w, x) : 2'b00;
    if (vis) begin
      e_val = 1;
      if (spc == 0) e_pix = {1'b0, bge};
      else if (bgc != 0 && m_bh[w]) e_pix = {1'b0, bge};
      else e_pix = {1'b1, m_pl[w], spc};
    end else begin
      e_val = 0;
    end
    set = vis && bus.show_bg && bus.show_spr && s0a
       && bgc != 0 && x != 255;
    if (sl == 261 && x == 1) e_hit = 0;
    else if (set && HIT) e_hit = 1;
    if (x == 256) model_clear();
    if (bus.load_en && x >= 257 && x <= 320) begin
      w = int'(bus.load_slot);
      m_x[w]  = int'(bus.load_x);
      m_lo[w] = bus.load_pt_lo;
      m_hi[w] = bus.load_pt_hi;
      m_hf[w] = bus.load_attr[6];
      m_bh[w] = bus.load_attr[5];
      m_pl[w] = bus.load_attr[1:0];
      m_s0[w] = HIT & bus.load_is_spr0;
    end
  endtask

  task automatic cycle(input int x);
    model_step();
    @(posedge clk);
    #1;
    chk("pixel", 32'(bus.pixel), 32'(e_pix));
    chk("valid", 32'(bus.pixel_valid), 32'(e_val));
    chk("hit", 32'(bus.spr0_hit), 32'(e_hit));
    if (x < 256) begin
      cap_pix[x] = bus.pixel;
      cap_hit[x] = bus.spr0_hit;
    end
  endtask

  task automatic sched_clear(input logic [3:0] bg);
    for (int x = 0; x < 341; x++) begin
      s_en[x] = 0; s_slot[x] = 0; s_x[x] = 0; s_attr[x] = 0;
      s_lo[x] = 0; s_hi[x] = 0; s_s0[x] = 0; bg_line[x] = bg;
    end
    l_sbg = 1; l_sspr = 1; l_sbgl = 1; l_ssprl = 1;
    rst_at = -1;
  endtask

  task automatic add_load(input int at, input int slot, input int sx,
                          input logic [7:0] attr, input logic [7:0] lo,
                          input logic [7:0] hi, input logic s0);
    s_en[at] = 1; s_slot[at] = slot; s_x[at] = sx;
    s_attr[at] = attr; s_lo[at] = lo; s_hi[at] = hi; s_s0[at] = s0;
  endtask

  task automatic run_line(input int sl);
    for (int x = 0; x < 341; x++) begin
      bus.x_idx = 10'(x);
      bus.scanline = 10'(sl);
      bus.bg_pixel = bg_line[x];
      bus.show_bg = l_sbg;
      bus.show_spr = l_sspr;
      bus.show_bg_left = l_sbgl;
      bus.show_spr_left = l_ssprl;
      bus.load_en = s_en[x];
      bus.load_slot = SW'(s_slot[x]);
      bus.load_x = 8'(s_x[x]);
      bus.load_attr = s_attr[x];
      bus.load_pt_lo = s_lo[x];
      bus.load_pt_hi = s_hi[x];
      bus.load_is_spr0 = s_s0[x];
      if (x == rst_at) begin
        reset_n = 0;
        #1;
        chk("rst_pix", 32'(bus.pixel), 32'h0);
        chk("rst_val", 32'(bus.pixel_valid), 32'h0);
        chk("rst_hit", 32'(bus.spr0_hit), 32'h0);
      end
      if (rst_at >= 0 && x == rst_at + 3) reset_n = 1;
      cycle(x);
    end
  endtask

  task automatic rand_line(input int sl);
    logic [3:0] r;
    sched_clear(4'h0);
    for (int x = 0; x < 341; x++) begin
      r = 4'($urandom_range(0, 15));
      if (r[1:0] == 2'b00) r = 4'h0;
      bg_line[x] = r;
      if ($urandom_range(0, 3) == 0)
        add_load(x, $urandom_range(0, NS - 1), $urandom_range(0, 255),
                 8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 5) == 0);
    end
    l_sbg = $urandom_range(0, 7) != 0;
    l_sspr = $urandom_range(0, 7) != 0;
    l_sbgl = $urandom_range(0, 3) != 0;
    l_ssprl = $urandom_range(0, 3) != 0;
    run_line(sl);
  endtask

  initial begin
    bus.x_idx = 0; bus.scanline = 0; bus.bg_pixel = 0;
    bus.show_bg = 0; bus.show_spr = 0;
    bus.show_bg_left = 0; bus.show_spr_left = 0;
    bus.load_en = 0; bus.load_slot = 0; bus.load_x = 0;
    bus.load_attr = 0; bus.load_pt_lo = 0; bus.load_pt_hi = 0;
    bus.load_is_spr0 = 0;
    model_clear();
    e_pix = 0; e_val = 0; e_hit = 0;
    #1;
    chk("reset_pix", 32'(bus.pixel), 32'h0);
    chk("reset_val", 32'(bus.pixel_valid), 32'h0);
    chk("reset_hit", 32'(bus.spr0_hit), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;

    sched_clear(4'h0);
    add_load(260, 0, 10, 8'h01, 8'h80, 8'h00, 0);
    run_line(0);

    sched_clear(4'h0);
    add_load(200, 0, 50, 8'h00, 8'hFF, 8'hFF, 0);
    add_load(270, 0, 10, 8'h41, 8'h01, 8'h00, 0);
    add_load(330, 1, 20, 8'h00, 8'hFF, 8'hFF, 0);
    run_line(1);
    chk("spr_x10", 32'(cap_pix[10]), 32'h15);
    for (int x = 11; x <= 17; x++)
      chk("spr_tail", 32'(cap_pix[x]), 32'h0);
    chk("ld_mid_line", 32'(cap_pix[251]), 32'h0);

    sched_clear(4'h0);
    add_load(260, 2, 40, 8'h02, 8'h80, 8'h80, 0);
    add_load(261, 5, 40, 8'h03, 8'h80, 8'h80, 0);
    run_line(2);
    chk("hflip_x10", 32'(cap_pix[10]), 32'h15);
    for (int x = 11; x <= 17; x++)
      chk("hflip_tail", 32'(cap_pix[x]), 32'h0);
    chk("ld_late", 32'(cap_pix[20]), 32'h0);

    sched_clear(4'h0);
    add_load(260, 1, 60, 8'h20, 8'h80, 8'h80, 0);
    add_load(261, 3, 70, 8'h20, 8'h80, 8'h80, 0);
    run_line(3);
    chk("slot_prio", 32'(cap_pix[40]), 32'h1B);

    sched_clear(4'h0);
    for (int x = 0; x < 341; x++) bg_line[x] = (x < 65) ? 4'h6 : 4'h4;
    add_load(260, 3, 100, 8'h00, 8'h80, 8'h80, 1);
    run_line(4);
    chk("behind_opq", 32'(cap_pix[60]), 32'h06);
    chk("behind_tr", 32'(cap_pix[70]), 32'h13);

    sched_clear(4'h5);
    run_line(5);
    chk("hit_before", 32'(cap_hit[99]), 32'h0);
    chk("hit_set", 32'(cap_hit[100]), 32'(HIT));
    chk("s0_pix", 32'(cap_pix[100]), 32'h13);

    sched_clear(4'h5);
    run_line(100);
    chk("hit_sticky", 32'(bus.spr0_hit), 32'(HIT));

    sched_clear(4'h5);
    add_load(260, 0, 248, 8'h00, 8'h01, 8'h00, 1);
    run_line(261);
    chk("hit_clr", 32'(bus.spr0_hit), 32'h0);

    sched_clear(4'h5);
    add_load(260, 0, 0, 8'h00, 8'hFF, 8'h00, 1);
    run_line(0);
    chk("x255_pix", 32'(cap_pix[255]), 32'h11);
    chk("x255_hit", 32'(cap_hit[255]), 32'h0);

    sched_clear(4'h5);
    l_sbgl = 0;
    add_load(260, 4, 100, 8'h02, 8'hFF, 8'hFF, 0);
    run_line(1);
    chk("left_pix", 32'(cap_pix[3]), 32'h11);
    chk("left_hit", 32'(cap_hit[7]), 32'h0);

    sched_clear(4'h5);
    rst_at = 50;
    run_line(2);
    chk("rst_nospr", 32'(cap_pix[100]), 32'h05);

    for (int n = 0; n < 20; n++) begin
      case ($urandom_range(0, 5))
        0: rand_line(261);
        1: rand_line(240);
        default: rand_line($urandom_range(0, 239));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
